useq_addr: RTL

Parametrised microsequencer address unit for the KS10 CPU: next-address selection (reset vector, page-fail trap, dispatch/skip/J merge), a registered current-address, a configurable-depth call/return stack with overflow/underflow detection, and a diagnostic breakpoint/halt/single-step facility. It sits between the dispatch/skip logic and the control ROM, and is the generalised successor of the fixed 12-bit sequencer address path.

---
 rtl/useq_pkg.sv | 17 +
 rtl/useq_addr_if.sv | 48 ++++
 rtl/useq_stack.sv | 117 +++++++++++
 rtl/useq_addr.sv | 85 ++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// useq_pkg: shared defaults and helpers for the microsequencer address unit.
//   AW_DEF        default microcode address width
//   DEPTH_DEF     default call/return stack depth
//   RESET_VEC_DEF default reset vector (sliced to AW by users)
//   depthWidth()  width of an occupancy count able to hold 0..entries
package useq_pkg;

  localparam int unsigned AW_DEF        = 12;
  localparam int unsigned DEPTH_DEF     = 16;
  localparam logic [31:0] RESET_VEC_DEF = 32'd0;

  // The count must represent "full" as well as "empty", hence the extra bit.
  function automatic int unsigned depthWidth(input int unsigned entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/useq_addr_if.sv
// useq_addr_if: bundle between the dispatch/skip logic (master) and the
// sequencer address unit (slave).
//   master drives : clken, pageFAIL, call, ret, dispADDR, skipADDR, cromJ,
//                   brkEN, brkADDR, cont, step, clrFLAGS
//   slave drives  : addr, curADDR, dispRET, halted, depth, stkOVF, stkUNF
interface useq_addr_if
  import useq_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
);

  localparam int unsigned DW = depthWidth(DEPTH);

  logic          clken;
  logic          pageFAIL;
  logic          call;
  logic          ret;
  logic [AW-1:0] dispADDR;
  logic [AW-1:0] skipADDR;
  logic [AW-1:0] cromJ;
  logic          brkEN;
  logic [AW-1:0] brkADDR;
  logic          cont;
  logic          step;
  logic          clrFLAGS;

  logic [AW-1:0] addr;
  logic [AW-1:0] curADDR;
  logic [AW-1:0] dispRET;
  logic          halted;
  logic [DW-1:0] depth;
  logic          stkOVF;
  logic          stkUNF;

  modport master (
    output clken, pageFAIL, call, ret, dispADDR, skipADDR, cromJ,
           brkEN, brkADDR, cont, step, clrFLAGS,
    input  addr, curADDR, dispRET, halted, depth, stkOVF, stkUNF
  );

  modport slave (
    input  clken, pageFAIL, call, ret, dispADDR, skipADDR, cromJ,
           brkEN, brkADDR, cont, step, clrFLAGS,
    output addr, curADDR, dispRET, halted, depth, stkOVF, stkUNF
  );

endinterface

// File: rtl/useq_stack.sv
// useq_stack: circular call/return stack.
//   clk, rst   clock, synchronous active-high reset
//   push, pop  stack requests (already qualified by the sequencer advance)
//   clrFlags   clears the sticky flags (a same-cycle set wins)
//   din        value to push
//   dout       registered top of stack, 0 when empty
//   depth      number of valid entries
//   ovf, unf   sticky overflow / underflow flags
module useq_stack
  import useq_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          clrFlags,
  input  logic [AW-1:0]                 din,
  output logic [AW-1:0]                 dout,
  output logic [depthWidth(DEPTH)-1:0]  depth,
  output logic                          ovf,
  output logic                          unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = depthWidth(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] topR, topN, wAddr;
  logic [DW-1:0] countR, countN;
  logic [AW-1:0] doutR, doutN;
  logic          ovfR, unfR, we, setOvf, setUnf;
  logic          full, empty;

  assign full  = (countR == DW'(DEPTH));
  assign empty = (countR == {DW{1'b0}});

  // Next pointer/count/top value. A push onto a full stack simply wraps onto
  // the oldest entry, which is what discards it.
  always_comb begin
    topN   = topR;
    countN = countR;
    doutN  = doutR;
    we     = 1'b0;
    wAddr  = topR;
    setOvf = 1'b0;
    setUnf = 1'b0;
    case ({push, pop})
      2'b11: begin
        // Replace the top in place; an empty stack gains its first entry.
        we    = 1'b1;
        doutN = din;
        if (empty) begin
          countN = DW'(1);
        end else begin
          countN = countR;
        end
      end
      2'b10: begin
        we    = 1'b1;
        wAddr = topR + PW'(1);
        topN  = topR + PW'(1);
        doutN = din;
        if (full) begin
          setOvf = 1'b1;
        end else begin
          countN = countR + DW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          setUnf = 1'b1;
          doutN  = {AW{1'b0}};
        end else begin
          countN = countR - DW'(1);
          topN   = topR - PW'(1);
          doutN  = (countR > DW'(1)) ? mem[topR - PW'(1)] : {AW{1'b0}};
        end
      end
      default: begin
        topN = topR;
      end
    endcase
  end

  // Stack bookkeeping registers and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      topR   <= {PW{1'b0}};
      countR <= {DW{1'b0}};
      doutR  <= {AW{1'b0}};
      ovfR   <= 1'b0;
      unfR   <= 1'b0;
    end else begin
      topR   <= topN;
      countR <= countN;
      doutR  <= doutN;
      ovfR   <= setOvf | (ovfR & ~clrFlags);
      unfR   <= setUnf | (unfR & ~clrFlags);
    end
  end

  // Entry storage; contents are meaningless outside the valid count.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wAddr] <= din;
    end
  end

  assign dout  = doutR;
  assign depth = countR;
  assign ovf   = ovfR;
  assign unf   = unfR;

endmodule

// File: rtl/useq_addr.sv
// useq_addr: microsequencer next-address unit.
//   clk, rst  clock, synchronous active-high reset
//   bus       useq_addr_if slave: address sources, stack requests and
//             breakpoint controls in; next address, current address, stack
//             top/depth/flags and halt status out
module useq_addr
  import useq_pkg::*;
#(
  parameter int unsigned   AW        = AW_DEF,
  parameter int unsigned   DEPTH     = DEPTH_DEF,
  parameter logic [AW-1:0] RESET_VEC = RESET_VEC_DEF[AW-1:0],
  parameter logic [AW-1:0] PF_VEC    = {AW{1'b1}}
) (
  input  logic      clk,
  input  logic      rst,
  useq_addr_if.slave bus
);

  logic          adv, stepOk, bpHit, push, pop;
  logic          haltedR, suppressR;
  logic [AW-1:0] addrS, curR;

  // Advance qualification, next-address select and breakpoint compare.
  always_comb begin
    // cont takes priority, so a step in the same cycle does nothing.
    stepOk = bus.step & ~bus.cont;
    adv    = bus.clken & (~haltedR | stepOk);
    if (rst) begin
      addrS = RESET_VEC;
    end else if (!adv) begin
      addrS = curR;
    end else if (bus.pageFAIL) begin
      addrS = PF_VEC;
    end else begin
      addrS = bus.dispADDR | bus.skipADDR | bus.cromJ;
    end
    bpHit = adv & bus.brkEN & ~haltedR & ~suppressR & (addrS == bus.brkADDR);
    push  = adv & (bus.call | bus.pageFAIL);
    pop   = adv & bus.ret & ~bus.pageFAIL;
  end

  // Current address, halt state and the one-shot compare suppression after cont.
  always_ff @(posedge clk) begin
    if (rst) begin
      curR      <= RESET_VEC;
      haltedR   <= 1'b0;
      suppressR <= 1'b0;
    end else begin
      if (adv) begin
        curR <= bpHit ? bus.brkADDR : addrS;
      end
      if (bus.cont) begin
        haltedR <= 1'b0;
      end else if (bpHit) begin
        haltedR <= 1'b1;
      end
      if (bus.cont) begin
        suppressR <= 1'b1;
      end else if (adv) begin
        suppressR <= 1'b0;
      end
    end
  end

  useq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) uStack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clrFlags (bus.clrFLAGS),
    .din      (curR),
    .dout     (bus.dispRET),
    .depth    (bus.depth),
    .ovf      (bus.stkOVF),
    .unf      (bus.stkUNF)
  );

  assign bus.addr    = addrS;
  assign bus.curADDR = curR;
  assign bus.halted  = haltedR;

endmodule
